// File: rtl/ir_pkg.sv
// NEC IR shared definitions: state encoding, segment lengths and carrier timing.
// Shared with the decoder so both sides agree on cycle counts at 50 MHz.
package ir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_BURST,
    LEAD_SPACE,
    RPT_SPACE,
    BIT_BURST,
    BIT_SPACE,
    STOP_BURST,
    GAP
  } ir_state_e;

  localparam int unsigned LEAD_BURST_CYC  = 450000;
  localparam int unsigned LEAD_SPACE_CYC  = 225000;
  localparam int unsigned RPT_SPACE_CYC   = 112500;
  localparam int unsigned BIT_BURST_CYC   = 28000;
  localparam int unsigned SPACE0_CYC      = 28000;
  localparam int unsigned SPACE1_CYC      = 84000;
  localparam int unsigned STOP_BURST_CYC  = 28000;
  localparam int unsigned GAP_CYC         = 2000000;

  localparam int unsigned CARR_PERIOD_CYC = 1316;
  localparam int unsigned CARR_HIGH_CYC   = 658;
  localparam int unsigned CARR_W          = 11;

  localparam int unsigned TMR_W = 21;
  typedef logic [TMR_W-1:0] tmr_t;

  // Timer counts down to zero, so a segment of len cycles loads len-1.
  function automatic tmr_t seg_load(input int unsigned len);
    return tmr_t'(len - 1);
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// 38 kHz carrier: free-running divider, forced to count 0 by restart.
// Output is combinational from the counter and gated by enable.
module ir_carrier_gen
  import ir_pkg::*;
#(
  parameter int unsigned PERIOD = CARR_PERIOD_CYC,
  parameter int unsigned HIGH   = CARR_HIGH_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic enable,
  output logic carrier
);

  logic [CARR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == CARR_W'(PERIOD - 1)) ? '0 : cnt_q + CARR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign carrier = enable && (cnt_q < CARR_W'(HIGH));

endmodule

// File: rtl/ir_encode.sv
// NEC IR transmitter: frames {data,addr} LSB first (or a repeat code) into an
// active-low envelope plus carrier-modulated LED drive; start is ignored while busy.
module ir_encode
  import ir_pkg::*;
#(
  parameter int unsigned LEAD_BURST_LEN = LEAD_BURST_CYC,
  parameter int unsigned LEAD_SPACE_LEN = LEAD_SPACE_CYC,
  parameter int unsigned RPT_SPACE_LEN  = RPT_SPACE_CYC,
  parameter int unsigned BIT_BURST_LEN  = BIT_BURST_CYC,
  parameter int unsigned SPACE0_LEN     = SPACE0_CYC,
  parameter int unsigned SPACE1_LEN     = SPACE1_CYC,
  parameter int unsigned STOP_BURST_LEN = STOP_BURST_CYC,
  parameter int unsigned GAP_LEN        = GAP_CYC,
  parameter int unsigned CARR_PERIOD    = CARR_PERIOD_CYC,
  parameter int unsigned CARR_HIGH      = CARR_HIGH_CYC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        rpt,
  input  logic [15:0] addr,
  input  logic [15:0] data,
  output logic        busy,
  output logic        done,
  output logic        ir_env,
  output logic        ir_led
);

  ir_state_e   state_q;
  tmr_t        tmr_q;
  logic [4:0]  idx_q;
  logic [31:0] frame_q;
  logic        rpt_q;
  logic        busy_q;
  logic        done_q;
  logic        env_q;

  logic tmr_end;
  logic enter_burst;
  logic burst;
  logic carrier;

  assign tmr_end = (tmr_q == '0);
  assign burst   = ~env_q;

  // Every space ends in a burst, so restart fires on any space expiry or on accept.
  always_comb begin
    enter_burst = 1'b0;
    case (state_q)
      IDLE:                             enter_burst = start;
      LEAD_SPACE, RPT_SPACE, BIT_SPACE: enter_burst = tmr_end;
      default:                          enter_burst = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      idx_q   <= '0;
      frame_q <= '0;
      rpt_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      env_q   <= 1'b1;
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE) begin
        tmr_q <= tmr_q - tmr_t'(1);
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            frame_q <= {data, addr};
            rpt_q   <= rpt;
            idx_q   <= '0;
            tmr_q   <= seg_load(LEAD_BURST_LEN);
            busy_q  <= 1'b1;
            env_q   <= 1'b0;
            state_q <= LEAD_BURST;
          end
        end
        LEAD_BURST: begin
          if (tmr_end) begin
            env_q <= 1'b1;
            if (rpt_q) begin
              tmr_q   <= seg_load(RPT_SPACE_LEN);
              state_q <= RPT_SPACE;
            end else begin
              tmr_q   <= seg_load(LEAD_SPACE_LEN);
              state_q <= LEAD_SPACE;
            end
          end
        end
        LEAD_SPACE: begin
          if (tmr_end) begin
            idx_q   <= '0;
            env_q   <= 1'b0;
            tmr_q   <= seg_load(BIT_BURST_LEN);
            state_q <= BIT_BURST;
          end
        end
        RPT_SPACE: begin
          if (tmr_end) begin
            env_q   <= 1'b0;
            tmr_q   <= seg_load(STOP_BURST_LEN);
            state_q <= STOP_BURST;
          end
        end
        BIT_BURST: begin
          if (tmr_end) begin
            env_q   <= 1'b1;
            tmr_q   <= frame_q[idx_q] ? seg_load(SPACE1_LEN) : seg_load(SPACE0_LEN);
            state_q <= BIT_SPACE;
          end
        end
        BIT_SPACE: begin
          if (tmr_end) begin
            env_q <= 1'b0;
            if (idx_q == 5'd31) begin
              tmr_q   <= seg_load(STOP_BURST_LEN);
              state_q <= STOP_BURST;
            end else begin
              idx_q   <= idx_q + 5'd1;
              tmr_q   <= seg_load(BIT_BURST_LEN);
              state_q <= BIT_BURST;
            end
          end
        end
        STOP_BURST: begin
          if (tmr_end) begin
            env_q   <= 1'b1;
            tmr_q   <= seg_load(GAP_LEN);
            state_q <= GAP;
          end
        end
        GAP: begin
          if (tmr_end) begin
            tmr_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  ir_carrier_gen #(
    .PERIOD (CARR_PERIOD),
    .HIGH   (CARR_HIGH)
  ) u_carrier (
    .clk     (clk),
    .reset   (reset),
    .restart (enter_burst),
    .enable  (burst),
    .carrier (carrier)
  );

  assign busy   = busy_q;
  assign done   = done_q;
  assign ir_env = env_q;
  assign ir_led = carrier & burst;

endmodule
